// File: rtl/tcm_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words
// and writes them to a TCM data port. The core is held in reset until the image has loaded cleanly.
module tcm_loader #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LOAD_BYTES      = 65536,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,

  output logic [31:0] mem_d_addr_o,
  output logic [31:0] mem_d_data_wr_o,
  output logic        mem_d_rd_o,
  output logic [3:0]  mem_d_wr_o,
  output logic        mem_d_cacheable_o,
  output logic [10:0] mem_d_req_tag_o,
  output logic        mem_d_invalidate_o,
  output logic        mem_d_writeback_o,
  output logic        mem_d_flush_o,

  input  logic [31:0] mem_d_data_rd_i,
  input  logic        mem_d_accept_i,
  input  logic        mem_d_ack_i,
  input  logic        mem_d_error_i,
  input  logic [10:0] mem_d_resp_tag_i,

  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned WORDS = LOAD_BYTES / 4;
  localparam int unsigned IDX_W = $clog2(WORDS + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [10:0]      etag_q, etag_d;
  logic             err_q, err_d;

  logic [31:0] idx_ext;
  logic        in_fill;
  logic        in_write;
  logic        can_issue;
  logic        issue;
  logic        wr_acc;
  logic        ack_ok;
  logic        ack_bad;
  logic        byte_acc;
  logic        last_word;

  // Read data is never consumed by a write-only loader.
  logic unused_rd;
  assign unused_rd = ^mem_d_data_rd_i;

  assign idx_ext   = 32'(idx_q);
  assign in_fill   = (state_q == ST_FILL);
  assign in_write  = (state_q == ST_WRITE);
  assign can_issue = (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign issue     = in_write && can_issue;
  assign wr_acc    = issue && mem_d_accept_i;
  assign ack_ok    = mem_d_ack_i && (outst_q != '0);
  assign byte_acc  = in_fill && byte_valid_i;
  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  assign ack_bad = mem_d_ack_i &&
                   (mem_d_error_i ||
                    (mem_d_resp_tag_i != etag_q) ||
                    (outst_q == '0));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    etag_d  = etag_q;
    err_d   = err_q | ack_bad;
    outst_d = outst_q;

    unique case (1'b1)
      (state_q == ST_FILL): begin
        if (byte_acc) begin
          // Shifting in from the top leaves the first byte in [7:0].
          word_d = {byte_data_i, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end
      (state_q == ST_WRITE): begin
        if (wr_acc) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = last_word ? ST_DRAIN : ST_FILL;
        end
      end
      (state_q == ST_DRAIN): begin
        if (outst_q == '0) begin
          state_d = ST_DONE;
        end
      end
      (state_q == ST_DONE): begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    unique case ({wr_acc, ack_ok})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (ack_ok) begin
      etag_d = etag_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      word_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      outst_q <= '0;
      etag_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      outst_q <= outst_d;
      etag_q  <= etag_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready_o = in_fill;

  assign mem_d_wr_o      = issue ? 4'hF : 4'h0;
  assign mem_d_addr_o    = in_write ? (BASE_ADDR + (idx_ext << 2)) : 32'h0;
  assign mem_d_data_wr_o = in_write ? word_q : 32'h0;
  assign mem_d_req_tag_o = in_write ? idx_ext[10:0] : 11'h0;

  assign mem_d_rd_o         = 1'b0;
  assign mem_d_cacheable_o  = 1'b1;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;

  assign done_o     = (state_q == ST_DONE);
  assign error_o    = err_q;
  assign core_rst_o = !((state_q == ST_DONE) && !err_q);

endmodule

// File: tb/tb_tcm_loader.sv
// Scoreboard bench for tcm_loader: a 3-word image at a base that wraps
// the 32-bit address space, with a scripted accept/ack memory model.
module tb_tcm_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFFC;
  localparam int unsigned NB   = 12;
  localparam int unsigned MO   = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [10:0] tag;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o;
  logic [31:0] mem_d_addr_o;
  logic [31:0] mem_d_data_wr_o;
  logic        mem_d_rd_o;
  logic [3:0]  mem_d_wr_o;
  logic        mem_d_cacheable_o;
  logic [10:0] mem_d_req_tag_o;
  logic        mem_d_invalidate_o;
  logic        mem_d_writeback_o;
  logic        mem_d_flush_o;
  logic [31:0] mem_d_data_rd_i = '0;
  logic        mem_d_accept_i = 1'b0;
  logic        mem_d_ack_i = 1'b0;
  logic        mem_d_error_i = 1'b0;
  logic [10:0] mem_d_resp_tag_i = '0;
  logic        core_rst_o;
  logic        done_o;
  logic        error_o;

  tcm_loader #(
    .BASE_ADDR(BASE),
    .LOAD_BYTES(NB),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o),
    .mem_d_addr_o(mem_d_addr_o),
    .mem_d_data_wr_o(mem_d_data_wr_o),
    .mem_d_rd_o(mem_d_rd_o),
    .mem_d_wr_o(mem_d_wr_o),
    .mem_d_cacheable_o(mem_d_cacheable_o),
    .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_invalidate_o(mem_d_invalidate_o),
    .mem_d_writeback_o(mem_d_writeback_o),
    .mem_d_flush_o(mem_d_flush_o),
    .mem_d_data_rd_i(mem_d_data_rd_i),
    .mem_d_accept_i(mem_d_accept_i),
    .mem_d_ack_i(mem_d_ack_i),
    .mem_d_error_i(mem_d_error_i),
    .mem_d_resp_tag_i(mem_d_resp_tag_i),
    .core_rst_o(core_rst_o),
    .done_o(done_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;

  wr_t         sb[$];
  logic [7:0]  byte_q[$];
  logic [10:0] pend[$];

  int          exp_idx = 0;
  int          nbytes = 0;
  logic [31:0] acc = '0;

  bit accept_en = 1'b0;
  bit ack_en = 1'b0;
  bit err_once = 1'b0;
  bit force_tag = 1'b0;
  bit spurious = 1'b0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_t e;
    byte_q.push_back(b);
    acc = {b, acc[31:8]};
    nbytes++;
    if (nbytes == 4) begin
      e.addr = BASE + (32'(exp_idx) << 2);
      e.data = acc;
      e.tag  = 11'(exp_idx);
      sb.push_back(e);
      exp_idx++;
      nbytes = 0;
    end
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom_range(0, 255)));
    end
  endtask

  // One cycle: inputs set at the negedge meet the current outputs at
  // the next posedge, so handshakes are recorded here.
  task automatic step();
    wr_t e;
    logic [10:0] t;
    @(negedge clk);
    mem_d_ack_i      = 1'b0;
    mem_d_error_i    = 1'b0;
    mem_d_resp_tag_i = '0;
    if (spurious) begin
      mem_d_ack_i = 1'b1;
      spurious = 1'b0;
    end else if (ack_en && pend.size() > 0) begin
      t = pend.pop_front();
      mem_d_ack_i = 1'b1;
      mem_d_resp_tag_i = force_tag ? 11'd5 : t;
      mem_d_error_i = err_once;
      force_tag = 1'b0;
      err_once = 1'b0;
    end
    if (byte_q.size() > 0) begin
      byte_valid_i = 1'b1;
      byte_data_i  = byte_q[0];
      if (byte_ready_o) begin
        void'(byte_q.pop_front());
      end
    end else begin
      byte_valid_i = 1'b0;
      byte_data_i  = '0;
    end
    mem_d_accept_i = accept_en;
    if (mem_d_wr_o != 4'h0 && accept_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        check_eq("sb_underrun", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", mem_d_addr_o, e.addr);
        check_eq("wr_data", mem_d_data_wr_o, e.data);
        check_eq("wr_tag", 32'(mem_d_req_tag_o), 32'(e.tag));
        check_eq("wr_strb", 32'(mem_d_wr_o), 32'hF);
      end
      pend.push_back(mem_d_req_tag_o);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
    end
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      step();
      n++;
    end
    check_eq("done", 32'(done_o), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    mem_d_accept_i = 1'b0;
    mem_d_ack_i = 1'b0;
    mem_d_error_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete();
    byte_q.delete();
    pend.delete();
    exp_idx = 0;
    nbytes = 0;
    acc = '0;
    n_wr = 0;
    err_once = 1'b0;
    force_tag = 1'b0;
    spurious = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    check_eq("rst_ready", 32'(byte_ready_o), 32'd1);
    check_eq("rst_wr", 32'(mem_d_wr_o), 32'd0);
    check_eq("rst_addr", mem_d_addr_o, 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err", 32'(error_o), 32'd0);
    check_eq("rst_core", 32'(core_rst_o), 32'd1);
    check_eq("tie_rd", 32'(mem_d_rd_o), 32'd0);
    check_eq("tie_cache", 32'(mem_d_cacheable_o), 32'd1);
    check_eq("tie_misc", 32'({mem_d_invalidate_o, mem_d_writeback_o,
                              mem_d_flush_o}), 32'd0);

    // Clean load, addresses wrap past 2^32
    accept_en = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(8'h11 * (i + 1)));
    end
    run_to_done(200);
    check_eq("t1_writes", 32'(n_wr), 32'd3);
    check_eq("t1_core", 32'(core_rst_o), 32'd0);
    check_eq("t1_err", 32'(error_o), 32'd0);
    check_eq("t1_sb", 32'(sb.size()), 32'd0);
    byte_q.push_back(8'h5A);
    run(4);
    check_eq("done_no_byte", 32'(byte_q.size()), 32'd1);
    check_eq("done_ready", 32'(byte_ready_o), 32'd0);
    check_eq("done_wr", 32'(mem_d_wr_o), 32'd0);
    check_eq("done_addr", mem_d_addr_o, 32'd0);

    // Withheld acks cap the writes in flight
    do_reset();
    accept_en = 1'b1;
    ack_en = 1'b0;
    send_rand(12);
    run(40);
    check_eq("t2_capped", 32'(n_wr), 32'd2);
    check_eq("t2_held_wr", 32'(mem_d_wr_o), 32'd0);
    check_eq("t2_ready", 32'(byte_ready_o), 32'd0);
    ack_en = 1'b1;
    run_to_done(200);
    check_eq("t2_writes", 32'(n_wr), 32'd3);
    check_eq("t2_core", 32'(core_rst_o), 32'd0);

    // Back-pressure on accept keeps the request stable
    do_reset();
    accept_en = 1'b0;
    ack_en = 1'b1;
    send_rand(4);
    n = 0;
    while (mem_d_wr_o == 4'h0 && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_wr", 32'(mem_d_wr_o), 32'hF);
      check_eq("hold_addr", mem_d_addr_o, sb[0].addr);
      check_eq("hold_data", mem_d_data_wr_o, sb[0].data);
      check_eq("hold_tag", 32'(mem_d_req_tag_o), 32'(sb[0].tag));
    end
    check_eq("hold_none", 32'(n_wr), 32'd0);
    accept_en = 1'b1;
    run(6);
    check_eq("hold_once", 32'(n_wr), 32'd1);
    send_rand(8);
    run_to_done(200);
    check_eq("t3_writes", 32'(n_wr), 32'd3);

    // Error response on word 0
    do_reset();
    accept_en = 1'b1;
    ack_en = 1'b1;
    err_once = 1'b1;
    send_rand(12);
    run_to_done(200);
    check_eq("t4_err", 32'(error_o), 32'd1);
    check_eq("t4_core", 32'(core_rst_o), 32'd1);

    // Tag mismatch, then a spurious ack with nothing outstanding
    do_reset();
    accept_en = 1'b1;
    ack_en = 1'b1;
    force_tag = 1'b1;
    send_rand(4);
    run(10);
    check_eq("t5_err", 32'(error_o), 32'd1);
    check_eq("t5_w0", 32'(n_wr), 32'd1);
    spurious = 1'b1;
    run(3);
    ack_en = 1'b0;
    send_rand(8);
    run(30);
    check_eq("t5_no_underflow", 32'(n_wr), 32'd3);
    ack_en = 1'b1;
    run_to_done(200);
    check_eq("t5_err_sticky", 32'(error_o), 32'd1);
    check_eq("t5_core", 32'(core_rst_o), 32'd1);

    // Reset mid-load discards the partial word
    do_reset();
    accept_en = 1'b1;
    ack_en = 1'b1;
    send_rand(6);
    run(30);
    check_eq("t6_pre", 32'(n_wr), 32'd1);
    do_reset();
    check_eq("t6_err", 32'(error_o), 32'd0);
    accept_en = 1'b1;
    ack_en = 1'b1;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    n = 0;
    while (n_wr == 0 && n < 50) begin
      step();
      n++;
    end
    check_eq("t6_first", 32'(n_wr), 32'd1);
    send_rand(8);
    run_to_done(200);
    check_eq("t6_err_end", 32'(error_o), 32'd0);
    check_eq("t6_core", 32'(core_rst_o), 32'd0);
    check_eq("t6_sb", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
